// File: rtl/infix_to_postfix.sv
// infix_to_postfix: operator-stack (shunting-yard) converter that turns an
// infix token stream into one gap-free postfix burst for the postfix evaluator.
// Optional feature macro: INFIX_PAREN_EN (4'b1000 = '(' and 4'b1001 = ')').
module infix_to_postfix #(
  parameter int MAX_TOK = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IN_VALID,
  input  logic [3:0] IN,
  input  logic       OP_MODE,
  output logic       OUT_VALID,
  output logic [3:0] OUT,
  output logic       OUT_MODE,
  output logic       BUSY,
  output logic       ERR
);
  localparam int CW = $clog2(MAX_TOK + 1);
  localparam int AW = (MAX_TOK > 1) ? $clog2(MAX_TOK) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_TOK);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0100;
`ifdef INFIX_PAREN_EN
  localparam logic [3:0] OP_LP  = 4'b1000;
  localparam logic [3:0] OP_RP  = 4'b1001;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CONV  = 3'd2,
    S_FLUSH = 3'd3,
    S_EMIT  = 3'd4
  } state_t;

  state_t        state_r;
  logic [3:0]    in_tok_r  [MAX_TOK];
  logic          in_mode_r [MAX_TOK];
  logic [3:0]    out_tok_r [MAX_TOK];
  logic          out_mode_r[MAX_TOK];
  logic [3:0]    stk_r     [MAX_TOK];
  logic [CW-1:0] cnt_r, rd_r, sp_r, ocnt_r, er_r;

  logic [3:0]    cur_tok_s, top_tok_s, out_wr_tok_s;
  logic          cur_mode_s, top_is_op_s, accept_s, flush_keep_s;
  logic          out_wr_s, out_wr_mode_s, push_s, pop_s, discard_s, adv_s, perr_s;
  logic [CW-1:0] sp_dec_s, sp_next_s, rd_next_s;

  // Operator codes accepted into the input buffer.
  function automatic logic op_legal(input logic [3:0] code);
    case (code)
      OP_ADD, OP_SUB, OP_MUL: op_legal = 1'b1;
`ifdef INFIX_PAREN_EN
      OP_LP, OP_RP:           op_legal = 1'b1;
`endif
      default:                op_legal = 1'b0;
    endcase
  endfunction

  // Binding strength; '(' ranks lowest so nothing pops past it.
  function automatic logic [1:0] prec(input logic [3:0] code);
    case (code)
      OP_MUL:         prec = 2'd2;
      OP_ADD, OP_SUB: prec = 2'd1;
      default:        prec = 2'd0;
    endcase
  endfunction

  // Fetch the token under the read pointer and the current stack top.
  always_comb begin
    sp_dec_s   = sp_r - CNT_ONE;
    cur_tok_s  = in_tok_r[rd_r[AW-1:0]];
    cur_mode_s = in_mode_r[rd_r[AW-1:0]];
    top_tok_s  = stk_r[sp_dec_s[AW-1:0]];
`ifdef INFIX_PAREN_EN
    top_is_op_s  = (sp_r != CNT_ZERO) && (top_tok_s != OP_LP);
    flush_keep_s = (top_tok_s != OP_LP);
`else
    top_is_op_s  = (sp_r != CNT_ZERO);
    flush_keep_s = 1'b1;
`endif
    accept_s = !OP_MODE || op_legal(IN);
  end

  // Choose the single conversion action for the current token.
  always_comb begin
    out_wr_s  = 1'b0;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    discard_s = 1'b0;
    adv_s     = 1'b0;
    perr_s    = 1'b0;
    if (!cur_mode_s) begin
      out_wr_s = 1'b1;
      adv_s    = 1'b1;
    end
`ifdef INFIX_PAREN_EN
    else if (cur_tok_s == OP_LP) begin
      push_s = 1'b1;
      adv_s  = 1'b1;
    end else if (cur_tok_s == OP_RP) begin
      if (sp_r == CNT_ZERO) begin
        perr_s = 1'b1;
        adv_s  = 1'b1;
      end else if (top_tok_s == OP_LP) begin
        discard_s = 1'b1;
        adv_s     = 1'b1;
      end else begin
        pop_s    = 1'b1;
        out_wr_s = 1'b1;
      end
    end
`endif
    else if (top_is_op_s && (prec(top_tok_s) >= prec(cur_tok_s))) begin
      pop_s    = 1'b1;
      out_wr_s = 1'b1;
    end else begin
      push_s = 1'b1;
      adv_s  = 1'b1;
    end
    out_wr_tok_s  = pop_s ? top_tok_s : cur_tok_s;
    out_wr_mode_s = pop_s ? 1'b1 : cur_mode_s;
    if (push_s) begin
      sp_next_s = sp_r + CNT_ONE;
    end else if (pop_s || discard_s) begin
      sp_next_s = sp_dec_s;
    end else begin
      sp_next_s = sp_r;
    end
    rd_next_s = adv_s ? (rd_r + CNT_ONE) : rd_r;
  end

  // Sequencer: load, convert, flush and stream, with registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r   <= S_IDLE;
      cnt_r     <= CNT_ZERO;
      rd_r      <= CNT_ZERO;
      sp_r      <= CNT_ZERO;
      ocnt_r    <= CNT_ZERO;
      er_r      <= CNT_ZERO;
      OUT_VALID <= 1'b0;
      OUT       <= 4'd0;
      OUT_MODE  <= 1'b0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
      for (int i = 0; i < MAX_TOK; i++) begin
        in_tok_r[i]   <= 4'd0;
        in_mode_r[i]  <= 1'b0;
        out_tok_r[i]  <= 4'd0;
        out_mode_r[i] <= 1'b0;
        stk_r[i]      <= 4'd0;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          OUT_VALID <= 1'b0;
          OUT       <= 4'd0;
          OUT_MODE  <= 1'b0;
          BUSY      <= 1'b0;
          if (IN_VALID) begin
            ERR    <= !accept_s;
            rd_r   <= CNT_ZERO;
            sp_r   <= CNT_ZERO;
            ocnt_r <= CNT_ZERO;
            er_r   <= CNT_ZERO;
            if (accept_s) begin
              in_tok_r[0]  <= IN;
              in_mode_r[0] <= OP_MODE;
              cnt_r        <= CNT_ONE;
            end else begin
              cnt_r <= CNT_ZERO;
            end
            state_r <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (IN_VALID) begin
            if (!accept_s || (cnt_r == CNT_MAX)) begin
              ERR <= 1'b1;
            end else begin
              in_tok_r[cnt_r[AW-1:0]]  <= IN;
              in_mode_r[cnt_r[AW-1:0]] <= OP_MODE;
              cnt_r <= cnt_r + CNT_ONE;
            end
          end else begin
            BUSY    <= 1'b1;
            state_r <= S_CONV;
          end
        end
        S_CONV: begin
          if (rd_r == cnt_r) begin
            state_r <= (sp_r == CNT_ZERO) ? S_EMIT : S_FLUSH;
          end else begin
            if (out_wr_s) begin
              out_tok_r[ocnt_r[AW-1:0]]  <= out_wr_tok_s;
              out_mode_r[ocnt_r[AW-1:0]] <= out_wr_mode_s;
              ocnt_r <= ocnt_r + CNT_ONE;
            end
            if (push_s) begin
              stk_r[sp_r[AW-1:0]] <= cur_tok_s;
            end
            if (perr_s) begin
              ERR <= 1'b1;
            end
            sp_r <= sp_next_s;
            rd_r <= rd_next_s;
            if (rd_next_s == cnt_r) begin
              state_r <= (sp_next_s == CNT_ZERO) ? S_EMIT : S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (sp_r == CNT_ZERO) begin
            state_r <= S_EMIT;
          end else begin
            if (flush_keep_s) begin
              out_tok_r[ocnt_r[AW-1:0]]  <= top_tok_s;
              out_mode_r[ocnt_r[AW-1:0]] <= 1'b1;
              ocnt_r <= ocnt_r + CNT_ONE;
            end else begin
              ERR <= 1'b1;
            end
            sp_r <= sp_dec_s;
            if (sp_dec_s == CNT_ZERO) begin
              state_r <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (er_r != ocnt_r) begin
            OUT_VALID <= 1'b1;
            OUT       <= out_tok_r[er_r[AW-1:0]];
            OUT_MODE  <= out_mode_r[er_r[AW-1:0]];
            er_r      <= er_r + CNT_ONE;
          end else begin
            OUT_VALID <= 1'b0;
            OUT       <= 4'd0;
            OUT_MODE  <= 1'b0;
            BUSY      <= 1'b0;
            state_r   <= S_IDLE;
          end
        end
        default: begin
          OUT_VALID <= 1'b0;
          BUSY      <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end
endmodule
